axi_to_vector: RTL
==================

Name: axi_to_vector

Overview:
AXI4 read-channel master that fetches a VLEN-element vector of 32-bit words from memory in a single INCR burst starting at START_ADDR. It presents the result as one flat bus, the read-side counterpart to the vector-to-AXI write path. It sits between the AXI interconnect and NN layer inputs. A read is triggered by a start pulse; the vector output changes only after a fully successful burst.

Parameters:
VLEN, 1, number of 32-bit elements per burst; legal range 1..256.
START_ADDR, 'hA000_0000, byte address of element 0; 4-byte aligned.
MAX_RETRY, 3, number of burst re-issues after an error response before giving up.

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to fetch the vector.
ar_addr  out  32  burst start address, constant START_ADDR.
ar_size  out  3  constant 3'b010 (4 bytes per beat).
ar_len  out  8  constant VLEN-1 (AXI beats minus one).
ar_burst  out  2  constant 2'b01 (INCR).
ar_valid  out  1  read address valid.
ar_ready  in  1  read address accepted.
r_data  in  32  read data beat.
r_resp  in  2  beat response; bit 1 set means SLVERR/DECERR.
r_last  in  1  last beat of burst.
r_valid  in  1  read data valid.
r_ready  out  1  master ready for read data.
vec  out  32*VLEN  last successfully read vector; element i at vec[32*i +: 32].
vec_valid  out  1  one-cycle pulse when vec is updated.
busy  out  1  high in any state except IDLE.
error  out  1  sticky; set when retries are exhausted or a burst-length mismatch occurs; cleared by the next accepted start or by rst.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, ar_valid=0, r_ready=0, vec=0, vec_valid=0, busy=0, error=0, beat counter=0, retry counter=0, shadow buffer=0. Reset mid-burst aborts immediately. Outstanding beats are never accepted because r_ready=0; the bench resets the slave together with the block.
- States: IDLE, ADDR, DATA, CHECK, DONE.
- IDLE: start=1 -> ADDR, clear error, retry counter and beat counter. start is ignored in every other state; there is no queueing.
- ADDR: ar_valid=1 starting the cycle after entry. Remain until ar_valid&ar_ready at an edge, then ar_valid=0 and go to DATA on the next cycle. ar_valid must not drop before the handshake.
- DATA: r_ready=1. Each edge with r_valid&r_ready is one beat:
  - if beat counter < VLEN, write r_data to shadow[32*cnt +: 32];
  - increment the counter (saturates at VLEN);
  - OR r_resp[1] into a burst-error flag.
  - Beats beyond VLEN are consumed and discarded.
  - On the beat with r_last=1: r_ready=0 next cycle, go to CHECK.
- CHECK (1 cycle): the burst fails if the error flag is set or beat count != VLEN (count includes the r_last beat).
  - Fail with retry counter < MAX_RETRY: increment retry, clear beat counter and error flag, go to ADDR.
  - Fail with retries exhausted: set error, go to IDLE, vec unchanged.
  - Length mismatch sets error immediately, with no retry.
  - Pass: go to DONE.
- DONE (1 cycle): vec <= shadow, vec_valid=1 for exactly this cycle, then IDLE.
- Latency with zero-wait slave (ar_ready=1, r_valid=1 every cycle):
  - start sampled at edge 0;
  - ar_valid high cycles 1;
  - beats at edges 2..VLEN+1;
  - CHECK at VLEN+2;
  - vec_valid at cycle VLEN+3.
- r_valid stalls (r_valid=0) add one cycle each and never corrupt the counter.
- busy = (state != IDLE).
- Outputs are registered; the ar_* constants are combinational ties.

Test Plan:
1. VLEN=4, zero-wait slave returning 32'h11,22,33,44 with OKAY -> one address handshake at START_ADDR with ar_len=3; vec={44,33,22,11}; vec_valid pulses once at cycle 7 after start; error=0.
2. ar_ready held low 5 cycles and r_valid toggling 1/0 on each beat -> ar_valid stays high until the handshake; vec still correct; vec_valid delayed by exactly the stall cycles.
3. Beat 2 returns r_resp=2'b10 on the first attempt and OKAY on the retry -> exactly two AR handshakes; vec holds the retry data; error=0.
4. MAX_RETRY=3 with every burst returning SLVERR -> 4 AR handshakes; then error=1, busy=0, vec keeps its previous value, no vec_valid.
5. VLEN=4, slave asserts r_last on beat 3 -> error=1, no retry, vec unchanged; start pulsed during the burst is ignored; a new start clears error.
6. rst asserted mid-DATA after 2 beats -> next cycle: ar_valid=0, r_ready=0, busy=0, vec=0; a subsequent start completes normally.

Source files
------------

// File: rtl/axi_to_vector.sv
// AXI4 read master: one INCR burst of VLEN words from START_ADDR, published as a flat vector.
// Latency: vec_valid VLEN+3 cycles after start with a zero-wait slave; AR/R stalls add cycle-for-cycle.
module axi_to_vector #(
  parameter int unsigned VLEN       = 1,
  parameter logic [31:0] START_ADDR = 32'hA000_0000,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [31:0]          ar_addr,
  output logic [2:0]           ar_size,
  output logic [7:0]           ar_len,
  output logic [1:0]           ar_burst,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  input  logic [31:0]          r_data,
  input  logic [1:0]           r_resp,
  input  logic                 r_last,
  input  logic                 r_valid,
  output logic                 r_ready,
  output logic [32*VLEN-1:0]   vec,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 error
);

  localparam int CW = $clog2(VLEN + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ADDR  = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]          r_state;
  logic                r_ar_valid;
  logic                r_r_ready;
  logic [32*VLEN-1:0]  r_vec;
  logic [32*VLEN-1:0]  r_shadow;
  logic                r_vec_valid;
  logic                r_error;
  logic [CW-1:0]       r_cnt;
  logic [RW-1:0]       r_retry;
  logic                r_berr;

  logic                w_beat;
  logic                w_len_bad;
  logic                w_can_retry;
  logic                w_unused_resp0;

  assign ar_addr   = START_ADDR;
  assign ar_size   = 3'b010;
  assign ar_len    = 8'(VLEN - 1);
  assign ar_burst  = 2'b01;
  assign ar_valid  = r_ar_valid;
  assign r_ready   = r_r_ready;
  assign vec       = r_vec;
  assign vec_valid = r_vec_valid;
  assign error     = r_error;
  assign busy      = (r_state != S_IDLE);

  // Only the error bit of the response matters; OKAY vs EXOKAY is irrelevant here.
  assign w_unused_resp0 = r_resp[0];

  assign w_beat      = r_valid & r_r_ready;
  assign w_len_bad   = (r_cnt != CW'(VLEN));
  assign w_can_retry = (r_retry < RW'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ar_valid  <= 1'b0;
      r_r_ready   <= 1'b0;
      r_vec       <= '0;
      r_shadow    <= '0;
      r_vec_valid <= 1'b0;
      r_error     <= 1'b0;
      r_cnt       <= '0;
      r_retry     <= '0;
      r_berr      <= 1'b0;
    end else begin
      r_vec_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ADDR;
            r_ar_valid <= 1'b1;
            r_error    <= 1'b0;
            r_retry    <= '0;
            r_cnt      <= '0;
            r_berr     <= 1'b0;
          end
        end
        S_ADDR: begin
          if (r_ar_valid && ar_ready) begin
            r_ar_valid <= 1'b0;
            r_r_ready  <= 1'b1;
            r_state    <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_beat) begin
            // Beats past VLEN fall through every compare and are dropped.
            for (int i = 0; i < int'(VLEN); i++) begin
              if (r_cnt == CW'(i)) r_shadow[32*i +: 32] <= r_data;
            end
            if (r_cnt != CW'(VLEN)) r_cnt <= r_cnt + CW'(1);
            r_berr <= r_berr | r_resp[1];
            if (r_last) begin
              r_r_ready <= 1'b0;
              r_state   <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // A short burst is a protocol fault, so it is never retried.
          if (w_len_bad) begin
            r_error <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_berr) begin
            if (w_can_retry) begin
              r_retry    <= r_retry + RW'(1);
              r_cnt      <= '0;
              r_berr     <= 1'b0;
              r_ar_valid <= 1'b1;
              r_state    <= S_ADDR;
            end else begin
              r_error <= 1'b1;
              r_state <= S_IDLE;
            end
          end else begin
            r_vec       <= r_shadow;
            r_vec_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
